wb_frame_packer: RTL and testbench
==================================

Name: wb_frame_packer

Overview:
- Parametrised Wishbone-stream frame packer for the OFDM TX chain.
- Accepts a continuous symbol stream on a Wishbone slave port and buffers it in an internal FIFO.
- Emits fixed-length frames on a Wishbone master port, with CYC_O framing each frame and a programmable inter-frame gap.
- Sits between the bit-symbol source and QPSK mod, replacing ad-hoc frame timing with a synthesizable block.

Parameters:
- DW, 2, symbol width (bits).
- DEPTH, 16, FIFO depth in symbols; power of 2, at least 4.
- AW, 4, log2(DEPTH).
- LEN_W, 12, width of FRM_LEN.
- GAP_W, 8, width of GAP_LEN.

Ports:
- CLK_I, in, 1, clock.
- RST_I, in, 1, synchronous active-low reset.
- DAT_I, in, DW, input symbol.
- WE_I / STB_I / CYC_I, in, 1 each, slave-side Wishbone qualifiers.
- ACK_O, out, 1, slave accept.
- DAT_O, out, DW, output symbol.
- WE_O / STB_O / CYC_O, out, 1 each, master-side qualifiers.
- ACK_I, in, 1, downstream accept.
- FRM_LEN, in, LEN_W, symbols per frame; sampled at frame start.
- GAP_LEN, in, GAP_W, idle cycles between frames; sampled at frame end.
- EN, in, 1, frame-start enable.
- BUSY, out, 1, high in BURST or GAP.
- FRM_CNT, out, 16, completed frames; wraps at 65535 -> 0.

Behaviour:
- Reset (RST_I==0 at posedge): FIFO emptied, state IDLE. DAT_O, STB_O, WE_O, CYC_O, BUSY and FRM_CNT all 0. ACK_O forced 0 while RST_I==0.
- Reset mid-frame: frame aborted, no further STB_O, FRM_CNT cleared.
- Slave push:
  - ACK_O = WE_I & STB_I & CYC_I & ~full & RST_I (combinational).
  - Symbol written at the posedge where ACK_O==1.
  - Push into a full FIFO is refused (ACK_O=0), even if a pop occurs in the same cycle.
- FIFO:
  - Show-ahead: DAT_O = head entry.
  - Count has AW+1 bits; pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- Master pop: a transfer occurs on a posedge with STB_O & ACK_I. It pops the FIFO and increments the symbol counter.
- State machine:
  - IDLE: CYC_O=0, STB_O=0.
    - If EN & ~empty & FRM_LEN!=0: latch FRM_LEN, clear symbol counter, go to BURST.
    - If FRM_LEN==0: stay in IDLE; no frame is emitted.
  - BURST: CYC_O=1, WE_O=1, STB_O = ~empty.
    - FIFO underrun holds CYC_O high with STB_O low (no abort).
    - On the transfer that makes the count equal the latched FRM_LEN: FRM_CNT+1 and latch GAP_LEN.
      - GAP_LEN==0: go to IDLE.
      - Otherwise: go to GAP.
    - EN deasserting mid-frame has no effect; the frame completes.
  - GAP: CYC_O=0, STB_O=0; counts GAP_LEN cycles, then goes to IDLE.
- Timing:
  - STB_O/CYC_O/WE_O are registered.
  - First push accepted at posedge k gives CYC_O=STB_O=1 in the cycle after posedge k+1 (2-cycle latency from IDLE).
  - With FIFO non-empty and EN=1, CYC_O is low for exactly GAP_LEN+1 cycles between frames.
  - With ACK_I held 1 and data available, a frame is FRM_LEN consecutive transfers.
- Changes to FRM_LEN/GAP_LEN during a frame take effect only at the next sample point.

Optional Feature:
- Macro FRM_UNDERRUN_CNT_EN.
- When defined: adds output port UNDERRUN_CNT [15:0].
  - Counts cycles in BURST with FIFO empty.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: RST_I=0 for 3 cycles with WE_I/STB_I/CYC_I=1 -> ACK_O=0; CYC_O, STB_O, WE_O, DAT_O, FRM_CNT all 0 throughout.
- Basic frames: FRM_LEN=4, GAP_LEN=3, ACK_I=1, EN=1; push 0,1,2,3,3,2,1,0 back-to-back -> two CYC_O windows of 4 cycles with DAT_O 0,1,2,3 then 3,2,1,0; CYC_O low exactly 4 cycles between; FRM_CNT=2.
- Backpressure: ACK_I=0, push 20 symbols -> ACK_O high for the first 16, then low. ACK_I=1 -> 16 symbols out in order, remaining 4 accepted as space frees; frames emitted per FRM_LEN.
- Underrun: FRM_LEN=4; push 2, wait 5 cycles, push 2 -> CYC_O high continuously, STB_O high 2 cycles, low 5+ cycles, high 2 cycles; FRM_CNT=1; UNDERRUN_CNT>=5 if FRM_UNDERRUN_CNT_EN.
- Zero length / GAP_LEN=0: FRM_LEN=0 with data -> CYC_O stays 0. Then FRM_LEN=2, GAP_LEN=0 -> CYC_O low exactly 1 cycle between frames.
- Reset mid-frame: assert RST_I=0 after the 2nd transfer of a 4-symbol frame -> next cycle CYC_O=0, FIFO empty, FRM_CNT=0. The next frame starts cleanly after new pushes.

Source files
------------

// File: rtl/wb_frame_packer.sv
// wb_frame_packer: buffers a Wishbone symbol stream and emits fixed-length CYC_O frames separated by a programmable gap.
// Define FRM_UNDERRUN_CNT_EN to add the saturating UNDERRUN_CNT output.
module wb_frame_packer #(
    parameter int DW    = 2,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int LEN_W = 12,
    parameter int GAP_W = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [DW-1:0]    DAT_I,
    input  logic             WE_I,
    input  logic             STB_I,
    input  logic             CYC_I,
    output logic             ACK_O,
    output logic [DW-1:0]    DAT_O,
    output logic             WE_O,
    output logic             STB_O,
    output logic             CYC_O,
    input  logic             ACK_I,
    input  logic [LEN_W-1:0] FRM_LEN,
    input  logic [GAP_W-1:0] GAP_LEN,
    input  logic             EN,
    output logic             BUSY,
    output logic [15:0]      FRM_CNT
`ifdef FRM_UNDERRUN_CNT_EN
    ,
    output logic [15:0]      UNDERRUN_CNT
`endif
);
    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t           state_q;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [LEN_W-1:0] len_q, sym_q, sym_d;
    logic [GAP_W-1:0] gap_q;
    logic [15:0]      frm_cnt_q;
    logic             cyc_q, stb_q;
    logic             full, empty, push, pop, last;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign push    = WE_I & STB_I & CYC_I & ~full & RST_I;
    assign pop     = stb_q & ACK_I;
    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign sym_d   = sym_q + LEN_W'(1);
    assign last    = pop & (sym_d == len_q);

    assign ACK_O   = push;
    assign DAT_O   = empty ? '0 : mem_q[rd_ptr_q];
    assign WE_O    = cyc_q;
    assign STB_O   = stb_q;
    assign CYC_O   = cyc_q;
    assign BUSY    = state_q != IDLE;
    assign FRM_CNT = frm_cnt_q;

    always_ff @(posedge CLK_I) begin
        if (push) mem_q[wr_ptr_q] <= DAT_I;
    end

    // STB_O looks at the post-update count so it never strobes an empty FIFO
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            len_q     <= '0;
            sym_q     <= '0;
            gap_q     <= '0;
            frm_cnt_q <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            case (state_q)
                IDLE: begin
                    if (EN && !empty && FRM_LEN != '0) begin
                        len_q   <= FRM_LEN;
                        sym_q   <= '0;
                        state_q <= BURST;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                    end
                end
                BURST: begin
                    if (pop) sym_q <= sym_d;
                    if (last) begin
                        frm_cnt_q <= frm_cnt_q + 16'd1;
                        gap_q     <= GAP_LEN;
                        state_q   <= (GAP_LEN == '0) ? IDLE : GAP;
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                    end else begin
                        stb_q <= count_d != '0;
                    end
                end
                GAP: begin
                    gap_q <= gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FRM_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    always_ff @(posedge CLK_I) begin
        if (!RST_I) underrun_q <= '0;
        else if (state_q == BURST && empty && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
    end

    assign UNDERRUN_CNT = underrun_q;
`endif
endmodule

// File: tb/tb_wb_frame_packer.sv
// tb_wb_frame_packer: directed bench for wb_frame_packer with a data scoreboard and CYC_O/STB_O run-length checks.
module tb_wb_frame_packer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  dat_i = '0;
    logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0, ack_i = 1'b0, en = 1'b0;
    logic [11:0] frm_len = '0;
    logic [7:0]  gap_len = '0;
    logic        ack_o, we_o, stb_o, cyc_o, busy;
    logic [1:0]  dat_o;
    logic [15:0] frm_cnt, base;
`ifdef FRM_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt, urun_base;
`endif

    int          n_assert = 0, n_fail = 0;
    logic [1:0]  sb [$];
    bit          rec = 1'b0;
    bit          cyc_h [$], stb_h [$];
    int          hi_r [$], lo_r [$];
    bit          got;

    always #5 clk = ~clk;

    wb_frame_packer dut (
        .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat_i), .WE_I(we_i), .STB_I(stb_i), .CYC_I(cyc_i),
        .ACK_O(ack_o), .DAT_O(dat_o), .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o), .ACK_I(ack_i),
        .FRM_LEN(frm_len), .GAP_LEN(gap_len), .EN(en), .BUSY(busy), .FRM_CNT(frm_cnt)
`ifdef FRM_UNDERRUN_CNT_EN
        , .UNDERRUN_CNT(underrun_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] d);
        dat_i = d;
        we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
        tick(1);
        we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
    endtask

    task automatic start_rec();
        cyc_h.delete();
        stb_h.delete();
        rec = 1'b1;
    endtask

    // Run lengths of highs, and of lows strictly between highs
    task automatic analyze(input bit use_stb);
        int hl, ll;
        bit seen, b;
        hl = 0; ll = 0; seen = 1'b0;
        hi_r.delete();
        lo_r.delete();
        for (int i = 0; i < cyc_h.size(); i++) begin
            b = use_stb ? stb_h[i] : cyc_h[i];
            if (b) begin
                if (seen && ll > 0) lo_r.push_back(ll);
                ll = 0; hl++; seen = 1'b1;
            end else begin
                if (hl > 0) hi_r.push_back(hl);
                hl = 0; ll++;
            end
        end
        if (hl > 0) hi_r.push_back(hl);
    endtask

    function automatic int hi_at(input int i);
        return (i < hi_r.size()) ? hi_r[i] : -1;
    endfunction

    function automatic int lo_at(input int i);
        return (i < lo_r.size()) ? lo_r[i] : -1;
    endfunction

    always @(negedge clk) begin
        logic [1:0] e;
        if (rec) begin
            cyc_h.push_back(cyc_o);
            stb_h.push_back(stb_o);
        end
        if (ack_o === 1'b1) sb.push_back(dat_i);
        if (rst_n && stb_o === 1'b1 && ack_i) begin
            e = 'x;
            if (sb.size() > 0) e = sb.pop_front();
            chk("dat_o", dat_o, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a pushing master
        we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1; dat_i = 2'd3;
        en = 1'b1; frm_len = 12'd4; ack_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", ack_o, 0);
            chk("rst_cyc", cyc_o, 0);
            chk("rst_stb", stb_o, 0);
            chk("rst_we", we_o, 0);
            chk("rst_dat", dat_o, 0);
            chk("rst_frm_cnt", frm_cnt, 0);
            chk("rst_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;

        // Basic frames
        frm_len = 12'd4; gap_len = 8'd3;
        start_rec();
        push(0); push(1); push(2); push(3); push(3); push(2); push(1); push(0);
        tick(30);
        rec = 1'b0;
        analyze(0);
        chk("basic_nfrm", hi_r.size(), 2);
        chk("basic_len0", hi_at(0), 4);
        chk("basic_len1", hi_at(1), 4);
        chk("basic_gap", lo_at(0), 4);
        chk("basic_frm_cnt", frm_cnt, 2);
        chk("basic_sb", sb.size(), 0);

        // Backpressure: fill, then drain while refilling
        ack_i = 1'b0; gap_len = 8'd1;
        for (int i = 0; i < 20; i++) begin
            dat_i = 2'(i ^ (i >> 2));
            we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
            @(negedge clk);
            chk("bp_ack", ack_o, i < 16);
            @(posedge clk);
            #1;
        end
        chk("bp_stall_stb", stb_o, 1);
        dat_i = 2'(16 ^ (16 >> 2));
        ack_i = 1'b1;
        @(negedge clk);
        chk("bp_full_pop_ack", ack_o, 0);
        @(posedge clk);
        #1;
        for (int j = 16; j < 20; j++) begin
            got = 1'b0;
            dat_i = 2'(j ^ (j >> 2));
            for (int b = 0; b < 20 && !got; b++) begin
                @(negedge clk);
                got = ack_o;
                @(posedge clk);
                #1;
            end
            chk("bp_refill", got, 1);
        end
        we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
        tick(60);
        chk("bp_frm_cnt", frm_cnt, 7);
        chk("bp_sb", sb.size(), 0);
        chk("bp_busy", busy, 0);

        // Underrun holds CYC_O with STB_O low
        gap_len = 8'd2;
        base = frm_cnt;
`ifdef FRM_UNDERRUN_CNT_EN
        urun_base = underrun_cnt;
`endif
        start_rec();
        push(0); push(1);
        tick(6);
        push(2); push(3);
        tick(12);
        rec = 1'b0;
        analyze(0);
        chk("ur_ncyc", hi_r.size(), 1);
        chk("ur_cyc_len", hi_at(0), 9);
        analyze(1);
        chk("ur_nstb", hi_r.size(), 2);
        chk("ur_stb0", hi_at(0), 2);
        chk("ur_stb1", hi_at(1), 2);
        chk("ur_stb_low", lo_at(0), 5);
        chk("ur_frm", frm_cnt - base, 1);
`ifdef FRM_UNDERRUN_CNT_EN
        chk("ur_cnt", underrun_cnt - urun_base, 5);
`endif

        // Zero length, then GAP_LEN=0
        frm_len = 12'd0; gap_len = 8'd0;
        start_rec();
        push(3); push(1); push(2); push(0);
        tick(6);
        rec = 1'b0;
        analyze(0);
        chk("zl_no_cyc", hi_r.size(), 0);
        chk("zl_busy", busy, 0);
        base = frm_cnt;
        start_rec();
        frm_len = 12'd2;
        tick(12);
        rec = 1'b0;
        analyze(0);
        chk("g0_nfrm", hi_r.size(), 2);
        chk("g0_len0", hi_at(0), 2);
        chk("g0_len1", hi_at(1), 2);
        chk("g0_gap", lo_at(0), 1);
        chk("g0_frm", frm_cnt - base, 2);
        chk("g0_sb", sb.size(), 0);

        // Reset after the 2nd transfer of a 4-symbol frame
        frm_len = 12'd4; gap_len = 8'd1;
        push(1); push(2); push(3); push(0);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mr_cyc", cyc_o, 0);
        chk("mr_stb", stb_o, 0);
        chk("mr_frm_cnt", frm_cnt, 0);
        chk("mr_dat", dat_o, 0);
        chk("mr_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        chk("mr_idle_cyc", cyc_o, 0);
        start_rec();
        push(2); push(3); push(1); push(1);
        tick(12);
        rec = 1'b0;
        analyze(0);
        chk("mr_nfrm", hi_r.size(), 1);
        chk("mr_len", hi_at(0), 4);
        chk("mr_frm_after", frm_cnt, 1);
        chk("mr_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
